// File: rtl/bin2rns_fwd_conv_pkg.sv
// Shared constants for the binary-to-RNS forward converter.
// RNS_REDUNDANT_EN adds the two redundant residue lanes.
package bin2rns_fwd_conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_FIX,
    S_DONE
  } state_e;

  localparam int unsigned CHUNK_W = 16;
  localparam int unsigned N_CHUNK = 3;

  localparam int unsigned DEF_MOD0 = 262049;
  localparam int unsigned DEF_MOD1 = 262069;
  localparam int unsigned DEF_MOD2 = 262079;
  localparam int unsigned DEF_MOD3 = 262103;

  localparam logic [63:0] DEF_M_HALF = 64'd34337459690;

`ifdef RNS_REDUNDANT_EN
  localparam int unsigned N_LANE = 4;
`else
  localparam int unsigned N_LANE = 2;
`endif

endpackage

// File: rtl/bin2rns_fwd_conv_horner_step.sv
// One Horner step of the forward converter:
// r_o = (r_i * 2^CHUNK_W + c_i) mod MODULUS, fully reduced.
module rns_horner_step
  import bin2rns_fwd_conv_pkg::*;
#(
  parameter int unsigned MODULUS    = DEF_MOD0,
  parameter int          DATA_WIDTH = 18
) (
  input  logic [DATA_WIDTH-1:0] r_i,
  input  logic [CHUNK_W-1:0]    c_i,
  output logic [DATA_WIDTH-1:0] r_o
);

  localparam int SW = DATA_WIDTH + CHUNK_W + 1;

  logic [SW-1:0] sum;

  // c_i < 2^CHUNK_W, so the shift-add is a plain concatenation
  assign sum = {1'b0, r_i, c_i};
  assign r_o = DATA_WIDTH'(sum % SW'(MODULUS));

endmodule

// File: rtl/bin2rns_fwd_conv.sv
// Signed binary to RNS residues, Horner over 16-bit chunks, MSB first.
// RNS_REDUNDANT_EN enables the MOD2/MOD3 lanes; otherwise dig2/dig3 are 0.
module bin2rns_fwd_conv
  import bin2rns_fwd_conv_pkg::*;
#(
  parameter int          DATA_WIDTH = 18,
  parameter int          IN_WIDTH   = 36,
  parameter int unsigned MOD0       = DEF_MOD0,
  parameter int unsigned MOD1       = DEF_MOD1,
  parameter int unsigned MOD2       = DEF_MOD2,
  parameter int unsigned MOD3       = DEF_MOD3,
  parameter logic [63:0] M_HALF     = DEF_M_HALF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] dig0,
  output logic [DATA_WIDTH-1:0] dig1,
  output logic [DATA_WIDTH-1:0] dig2,
  output logic [DATA_WIDTH-1:0] dig3,
  output logic                  ovf
);

  localparam int MW = IN_WIDTH + 1;
  localparam int PW = CHUNK_W * N_CHUNK;
  localparam logic [MW-1:0] MH = M_HALF[MW-1:0];
  localparam int unsigned MODS [4] = '{MOD0, MOD1, MOD2, MOD3};

  state_e              state_q, state_d;
  logic                neg_q;
  logic                ovf_q;
  logic                init_q;
  logic [1:0]          cnt_q;
  logic [MW-1:0]       mag_q;
  logic [MW-1:0]       sx, mag_d;
  logic [PW-1:0]       pad;
  logic [CHUNK_W-1:0]  chunk;
  logic                acc;
  logic                last;
  logic [DATA_WIDTH-1:0] dig_w [4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (acc) state_d = S_ACC;
      S_ACC:  if (last) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // init_q keeps in_ready low until the first edge after reset release
  always_comb begin
    in_ready  = (state_q == S_IDLE) && init_q;
    out_valid = (state_q == S_DONE);
  end

  assign acc  = in_valid && in_ready;
  assign last = (cnt_q == 2'(N_CHUNK - 1));

  // MW bits so that the most negative input has an exact magnitude
  assign sx    = {bin_in[IN_WIDTH-1], bin_in};
  assign mag_d = bin_in[IN_WIDTH-1] ? -sx : sx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg_q  <= 1'b0;
      mag_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (acc) begin
        neg_q <= bin_in[IN_WIDTH-1];
        mag_q <= mag_d;
        ovf_q <= (mag_d > MH);
      end
      if (state_q == S_ACC) cnt_q <= cnt_q + 2'd1;
      else                  cnt_q <= '0;
    end
  end

  assign pad = PW'(mag_q);

  always_comb begin
    chunk = '0;
    unique case (cnt_q)
      2'd0:    chunk = pad[PW-1 -: CHUNK_W];
      2'd1:    chunk = pad[PW-CHUNK_W-1 -: CHUNK_W];
      default: chunk = pad[CHUNK_W-1:0];
    endcase
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    if (k < N_LANE) begin : g_on
      localparam logic [DATA_WIDTH-1:0] MK = DATA_WIDTH'(MODS[k]);

      logic [DATA_WIDTH-1:0] r_q, r_d, step;

      rns_horner_step #(
        .MODULUS    (MODS[k]),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_step (
        .r_i (r_q),
        .c_i (chunk),
        .r_o (step)
      );

      always_comb begin
        r_d = r_q;
        unique case (state_q)
          S_IDLE: if (acc) r_d = '0;
          S_ACC:  r_d = step;
          S_FIX:  if (neg_q && (r_q != '0)) r_d = MK - r_q;
          default: r_d = r_q;
        endcase
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_q <= '0;
        else          r_q <= r_d;
      end

      assign dig_w[k] = r_q;
    end else begin : g_off
      assign dig_w[k] = '0;
    end
  end

  assign dig0 = dig_w[0];
  assign dig1 = dig_w[1];
  assign dig2 = dig_w[2];
  assign dig3 = dig_w[3];
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2rns_fwd_conv.sv
// Directed bench for bin2rns_fwd_conv; expected residues hand-computed.
// Redundant-digit expectations switch with RNS_REDUNDANT_EN.
module tb_bin2rns_fwd_conv;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [35:0] bin_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [17:0] dig0, dig1, dig2, dig3;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  bin2rns_fwd_conv dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dig0      (dig0),
    .dig1      (dig1),
    .dig2      (dig2),
    .dig3      (dig3),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".in_ready"}, longint'(in_ready), 1);
  endtask

  task automatic run(input string tag, input longint x,
                     input longint e0, input longint e1,
                     input longint e2, input longint e3,
                     input longint eovf);
    int n;
    wait_ready(tag);
    in_valid = 1'b1;
    bin_in   = x[35:0];
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
`ifndef RNS_REDUNDANT_EN
    e2 = 0;
    e3 = 0;
`endif
    chk({tag, ".lat"}, n, 4);
    chk({tag, ".dig0"}, dig0, e0);
    chk({tag, ".dig1"}, dig1, e1);
    chk({tag, ".dig2"}, dig2, e2);
    chk({tag, ".dig3"}, dig3, e3);
    chk({tag, ".ovf"}, ovf, eovf);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".vld_drop"}, out_valid, 0);
    chk({tag, ".rdy_back"}, in_ready, 1);
  endtask

  initial begin
    #23;
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.dig0", dig0, 0);
    chk("rst.dig1", dig1, 0);
    chk("rst.dig2", dig2, 0);
    chk("rst.dig3", dig3, 0);
    chk("rst.ovf", ovf, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst.rdy_early", in_ready, 0);
    @(negedge clk);
    chk("rst.rdy_1cyc", in_ready, 1);

    run("one", 1, 1, 1, 1, 1, 0);
    run("m1", -1, 262048, 262068, 262078, 262102, 0);
    run("p2_20", 1048576, 380, 300, 260, 164, 0);
    run("mod0", 262049, 0, 262049, 262049, 262049, 0);
    run("zero", 0, 0, 0, 0, 0, 0);
    run("nmod0", -262049, 0, 20, 30, 54, 0);
    run("mhalf", 64'sd34337459690, 131024, 131034, 131189, 131969, 0);
    run("mhalf1", 64'sd34337459691, 131025, 131035, 131190, 131970, 1);
    run("neg2_35", -64'sd34359738368, 126512, 128222, 128927, 130211, 1);

    // consumer stall: outputs hold, new requests ignored
    wait_ready("bp");
    in_valid = 1'b1;
    bin_in   = 36'd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      bin_in   = 36'd999;
      @(negedge clk);
      chk("bp.out_valid", out_valid, 1);
      chk("bp.dig0", dig0, 5);
      chk("bp.dig1", dig1, 5);
      chk("bp.in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.vld_drop", out_valid, 0);
    chk("bp.rdy_back", in_ready, 1);
    repeat (6) @(negedge clk);
    chk("bp.no_buffer", out_valid, 0);

    // reset in the middle of accumulation aborts the transaction
    wait_ready("ab");
    in_valid = 1'b1;
    bin_in   = 36'd34337459691;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("ab.ovf", ovf, 0);
    chk("ab.in_ready", in_ready, 0);
    chk("ab.out_valid", out_valid, 0);
    chk("ab.dig0", dig0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ab.quiet", out_valid, 0);
    end
    chk("ab.idle", in_ready, 1);

    run("post", -1, 262048, 262068, 262078, 262102, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
